// File: rtl/console_writer.sv
// console_writer: byte stream to text-console cell writes.
// Tracks a cursor, interprets LF/CR/BS/FF, scrolls via a private shadow copy
// of the screen (no VRAM read-back), and clears rows or the whole screen.
// Optional build macro: CONSOLE_WRITER_CLEAR_ON_RESET_EN -- clear the screen
// (VRAM and shadow) automatically after reset is released.
module console_writer #(
  parameter int COLS = 90,
  parameter int ROWS = 30,
  parameter logic [7:0] ATTR_INIT = 8'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        attr_we,
  input  logic [7:0]  attr_in,
  output logic [31:0] a,
  output logic [31:0] d,
  output logic        we,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y
);

  typedef enum logic [2:0] {IDLE, PUT, SCROLL, CLRROW, CLRALL} state_t;

  localparam logic [6:0]  X_LAST      = 7'(COLS - 1);
  localparam logic [4:0]  Y_LAST      = 5'(ROWS - 1);
  localparam logic [11:0] COLS12      = 12'(COLS);
  localparam logic [11:0] SCROLL_LAST = 12'((ROWS - 1) * COLS - 1);
  localparam logic [11:0] ROW_BASE    = 12'((ROWS - 1) * COLS);
  localparam logic [11:0] ALL_LAST    = 12'(ROWS * COLS - 1);
  localparam logic [7:0]  SPACE       = 8'h20;

  state_t      state;
  logic [11:0] cnt;
  logic [7:0]  attr;
  logic [15:0] rd_data;
  logic [15:0] shadow [0:4095];

  logic        accept;
  logic        printable;
  logic        wr_en;
  logic [11:0] wr_idx;
  logic [15:0] wr_cell;
  logic [11:0] rd_idx;
  logic [11:0] cur_idx;

  // Next cell write (shared by the VRAM output registers and the shadow copy)
  always_comb begin
    accept    = (state == IDLE) && ch_ready && ch_valid;
    printable = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
    cur_idx   = {7'b0, cur_y} * COLS12 + {5'b0, cur_x};
    wr_en     = 1'b0;
    wr_idx    = 12'd0;
    wr_cell   = 16'd0;
    // Scroll reads run one cell ahead so the data is ready when written back
    rd_idx    = (state == SCROLL) ? (cnt + COLS12 + 12'd1) : COLS12;
    case (state)
      IDLE: if (accept && printable) begin
        wr_en = 1'b1; wr_idx = cur_idx; wr_cell = {attr, ch_data};
      end
      SCROLL: begin
        wr_en = 1'b1; wr_idx = cnt; wr_cell = rd_data;
      end
      CLRROW: begin
        wr_en = 1'b1; wr_idx = ROW_BASE + cnt; wr_cell = {attr, SPACE};
      end
      CLRALL: begin
        wr_en = 1'b1; wr_idx = cnt; wr_cell = {attr, SPACE};
      end
      default: ;
    endcase
  end

  // Shadow screen RAM: mirrors every VRAM write, registered read for scrolling
  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      shadow[wr_idx] <= wr_cell;
    rd_data <= shadow[rd_idx];
  end

  // Control FSM with registered VRAM bus, ready and cursor outputs
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef CONSOLE_WRITER_CLEAR_ON_RESET_EN
      state <= CLRALL;
`else
      state <= IDLE;
`endif
      cnt      <= 12'd0;
      attr     <= ATTR_INIT;
      cur_x    <= 7'd0;
      cur_y    <= 5'd0;
      ch_ready <= 1'b0;
      we       <= 1'b0;
      a        <= 32'd0;
      d        <= 32'd0;
    end else begin
      we <= wr_en;
      if (wr_en) begin
        a <= {18'b0, wr_idx, 2'b00};
        d <= {16'b0, wr_cell};
      end
      // Ready drops for any multi-cycle operation and for the cycle showing
      // the final write of a clear; it returns on the following IDLE edge.
      ch_ready <= 1'b0;
      case (state)
        IDLE: begin
          ch_ready <= 1'b1;
          if (ch_ready && attr_we)
            attr <= attr_in;
          if (accept) begin
            if (printable) begin
              state    <= PUT;
              ch_ready <= 1'b0;
            end else if (ch_data == 8'h0A) begin
              cur_x <= 7'd0;
              if (cur_y == Y_LAST) begin
                state    <= SCROLL;
                cnt      <= 12'd0;
                ch_ready <= 1'b0;
              end else begin
                cur_y <= cur_y + 5'd1;
              end
            end else if (ch_data == 8'h0D) begin
              cur_x <= 7'd0;
            end else if (ch_data == 8'h08) begin
              if (cur_x != 7'd0)
                cur_x <= cur_x - 7'd1;
            end else if (ch_data == 8'h0C) begin
              state    <= CLRALL;
              cnt      <= 12'd0;
              ch_ready <= 1'b0;
            end
          end
        end
        PUT: begin
          if (cur_x == X_LAST) begin
            cur_x <= 7'd0;
            if (cur_y == Y_LAST) begin
              state <= SCROLL;
              cnt   <= 12'd0;
            end else begin
              cur_y    <= cur_y + 5'd1;
              state    <= IDLE;
              ch_ready <= 1'b1;
            end
          end else begin
            cur_x    <= cur_x + 7'd1;
            state    <= IDLE;
            ch_ready <= 1'b1;
          end
        end
        SCROLL: begin
          if (cnt == SCROLL_LAST) begin
            state <= CLRROW;
            cnt   <= 12'd0;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        CLRROW: begin
          if (cnt == 12'(COLS - 1))
            state <= IDLE;
          else
            cnt <= cnt + 12'd1;
        end
        CLRALL: begin
          if (cnt == ALL_LAST) begin
            state <= IDLE;
            cur_x <= 7'd0;
            cur_y <= 5'd0;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
